// File: rtl/uart_tx_if.sv
// Parallel-side handshake of the UART transmitter: byte, start request,
// ready indication and end-of-frame pulse.
interface uart_tx_if #(
  parameter int DW = 8
);
  logic [DW-1:0] tx_data;
  logic          tx_start;
  logic          tx_ready;
  logic          tx_done;

  // Producer of bytes (loopback/test logic)
  modport master (
    output tx_data,
    output tx_start,
    input  tx_ready,
    input  tx_done
  );

  // The transmitter itself
  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_ready,
    output tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DW data bits LSB-first, optional parity bit,
// stop bit. Each bit is held for CLKS_PER_BIT clocks. The serial line and the
// handshake outputs all come straight from flops.
module uart_tx #(
  parameter int DW           = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus,
  output logic      tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic [CW-1:0]   baud_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [DW-1:0]   shift_reg;
  logic [DW-1:0]   shift_nxt;
  logic            par_bit;
  logic            baud_end;
  logic            tx_r;
  logic            ready_r;
  logic            done_r;

  // Parity over the latched byte; odd parity is the inverted XOR reduction.
  function automatic logic parity_of(input logic [DW-1:0] d);
    return (PARITY_ODD != 0) ? ~(^d) : (^d);
  endfunction

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign shift_nxt = shift_reg >> 1;

  // Frame sequencer: state, bit timing, shifting and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tx_r      <= 1'b1;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state != IDLE) begin
        baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          tx_r     <= 1'b1;
          ready_r  <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (bus.tx_start) begin
            shift_reg <= bus.tx_data;
            par_bit   <= parity_of(bus.tx_data);
            state     <= START;
            tx_r      <= 1'b0;
            ready_r   <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_r    <= shift_reg[0];
          end
        end
        DATA: begin
          if (baud_end) begin
            if (bit_cnt == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx_r  <= par_bit;
              end else begin
                state <= STOP;
                tx_r  <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_nxt;
              tx_r      <= shift_nxt[0];
            end
          end
        end
        PARITY: begin
          if (baud_end) begin
            state <= STOP;
            tx_r  <= 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            state   <= IDLE;
            tx_r    <= 1'b1;
            ready_r <= 1'b1;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx_r    <= 1'b1;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign tx           = tx_r;
  assign bus.tx_ready = ready_r;
  assign bus.tx_done  = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (even parity, odd parity, no parity)
// share clock and reset; expected line levels are queued per bit when a byte
// is sent and compared bit by bit as the selected instance transmits.
module tb_uart_tx;

  localparam int CPB = 434;

  logic       clk;
  logic       rst;
  logic [7:0] drv_data;
  logic       drv_start;
  int         sel;
  logic       tx0, tx1, tx2;
  logic       cur_tx, cur_ready, cur_done;

  int checks;
  int errors;
  int cyc;
  int done_cnt0, done_cnt1, done_cnt2;
  logic exp_q[$];

  uart_tx_if #(.DW(8)) if0 ();
  uart_tx_if #(.DW(8)) if1 ();
  uart_tx_if #(.DW(8)) if2 ();

  assign if0.tx_data  = drv_data;
  assign if1.tx_data  = drv_data;
  assign if2.tx_data  = drv_data;
  assign if0.tx_start = drv_start && (sel == 0);
  assign if1.tx_start = drv_start && (sel == 1);
  assign if2.tx_start = drv_start && (sel == 2);

  uart_tx #(.DW(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
    .clk(clk), .rst(rst), .bus(if0), .tx(tx0));
  uart_tx #(.DW(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .bus(if1), .tx(tx1));
  uart_tx #(.DW(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut_nopar (
    .clk(clk), .rst(rst), .bus(if2), .tx(tx2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if0.tx_done === 1'b1) done_cnt0 <= done_cnt0 + 1;
    if (if1.tx_done === 1'b1) done_cnt1 <= done_cnt1 + 1;
    if (if2.tx_done === 1'b1) done_cnt2 <= done_cnt2 + 1;
  end

  always_comb begin
    cur_tx    = tx0;
    cur_ready = if0.tx_ready;
    cur_done  = if0.tx_done;
    case (sel)
      1: begin cur_tx = tx1; cur_ready = if1.tx_ready; cur_done = if1.tx_done; end
      2: begin cur_tx = tx2; cur_ready = if2.tx_ready; cur_done = if2.tx_done; end
      default: ;
    endcase
  end

  // Queue the expected line levels of one frame, then pulse tx_start.
  task automatic send(input logic [7:0] d, input bit par_en, input bit par_odd,
                      input bit keep_start);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (par_en) exp_q.push_back(((ones % 2) == 1) ^ par_odd);
    exp_q.push_back(1'b1);
    drv_data  = d;
    drv_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!keep_start) drv_start = 1'b0;
  endtask

  // Follow one frame of the selected instance, popping nbits expected levels.
  task automatic watch_frame(input string name, input int nbits,
                             output int t_start, output int t_done);
    int   waited;
    bit   ok;
    logic b;
    logic bad;
    waited  = 0;
    t_start = 0;
    t_done  = 0;
    while (cur_tx !== 1'b0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (cur_tx !== 1'b0) begin
      errors++;
      $display("FAIL %s start_bit: line=%b after %0d cycles, required 0", name, cur_tx, waited);
      return;
    end
    t_start = cyc;
    for (int i = 0; i < nbits; i++) begin
      if (exp_q.size() == 0) b = 1'bx;
      else b = exp_q.pop_front();
      ok  = 1'b1;
      bad = b;
      for (int c = 0; c < CPB; c++) begin
        if (cur_tx !== b || cur_ready !== 1'b0) begin
          ok  = 1'b0;
          bad = cur_tx;
        end
        @(negedge clk);
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s bit%0d: line=%b ready=%b, required line=%b ready=0 for %0d cycles",
                 name, i, bad, cur_ready, b, CPB);
      end
    end
    t_done = cyc;
    checks++;
    if (cur_done !== 1'b1 || cur_ready !== 1'b1 || cur_tx !== 1'b1) begin
      errors++;
      $display("FAIL %s end: done=%b ready=%b line=%b, required 1 1 1",
               name, cur_done, cur_ready, cur_tx);
    end
    checks++;
    if (t_done - t_start != nbits * CPB) begin
      errors++;
      $display("FAIL %s length: %0d cycles, required %0d", name, t_done - t_start, nbits * CPB);
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx0 !== 1'b1 || if0.tx_ready !== 1'b1 || if0.tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: tx=%b ready=%b done=%b, required 1 1 0",
               tx0, if0.tx_ready, if0.tx_done);
    end
    ok = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || tx1 !== 1'b1 || tx2 !== 1'b1 ||
          if0.tx_ready !== 1'b1 || if1.tx_ready !== 1'b1 || if2.tx_ready !== 1'b1 ||
          if0.tx_done !== 1'b0 || if1.tx_done !== 1'b0 || if2.tx_done !== 1'b0)
        ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_hold: tx=%b%b%b ready=%b%b%b, required all 1 for 1000 cycles",
               tx0, tx1, tx2, if0.tx_ready, if1.tx_ready, if2.tx_ready);
    end
    // Reset and start together: reset wins, the request is dropped.
    sel       = 0;
    rst       = 1'b1;
    drv_data  = 8'hAA;
    drv_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    drv_start = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (tx0 !== 1'b1 || if0.tx_ready !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!ok || done_cnt0 != 0) begin
      errors++;
      $display("FAIL rst_with_start: tx=%b ready=%b dones=%0d, required 1 1 0",
               tx0, if0.tx_ready, done_cnt0);
    end
  endtask

  task automatic test_single_frame();
    int ts, td, d0;
    sel = 0;
    d0  = done_cnt0;
    send(8'h55, 1'b1, 1'b0, 1'b0);
    watch_frame("even_0x55", 11, ts, td);
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt0 - d0 != 1) begin
      errors++;
      $display("FAIL even_0x55 done_count: %0d, required 1", done_cnt0 - d0);
    end
  endtask

  task automatic test_parity_modes();
    int ts, td, d2;
    sel = 1;
    send(8'h00, 1'b1, 1'b1, 1'b0);
    watch_frame("odd_0x00", 11, ts, td);
    repeat (3) @(negedge clk);
    send(8'h01, 1'b1, 1'b1, 1'b0);
    watch_frame("odd_0x01", 11, ts, td);
    repeat (3) @(negedge clk);
    sel = 2;
    d2  = done_cnt2;
    send(8'hA3, 1'b0, 1'b0, 1'b0);
    watch_frame("nopar_0xA3", 10, ts, td);
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt2 - d2 != 1) begin
      errors++;
      $display("FAIL nopar done_count: %0d, required 1", done_cnt2 - d2);
    end
    sel = 0;
  endtask

  task automatic test_busy_reject();
    int ts, td, d0;
    bit ok;
    sel = 0;
    d0  = done_cnt0;
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    fork
      watch_frame("busy_0x3C", 11, ts, td);
      begin
        repeat (1000) @(negedge clk);
        drv_data  = 8'hFF;
        drv_start = 1'b1;
        @(negedge clk);
        drv_start = 1'b0;
      end
    join
    ok = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (tx0 !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok || done_cnt0 - d0 != 1) begin
      errors++;
      $display("FAIL busy_reject: dones=%0d idle_ok=%0d, required 1 dones and idle line",
               done_cnt0 - d0, ok);
    end
  endtask

  task automatic test_back_to_back();
    int ts1, td1, ts2, td2, d0;
    sel = 0;
    d0  = done_cnt0;
    send(8'h12, 1'b1, 1'b0, 1'b1);
    drv_data = 8'h34;
    // Second frame's expectations queued as the held request will restart it.
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(((8'h34 >> i) & 1) != 0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    watch_frame("b2b_0x12", 11, ts1, td1);
    @(posedge clk);
    @(negedge clk);
    drv_start = 1'b0;
    watch_frame("b2b_0x34", 11, ts2, td2);
    checks++;
    if (ts2 - td1 != 1) begin
      errors++;
      $display("FAIL b2b_gap: %0d idle cycles, required 1", ts2 - td1);
    end
    repeat (500) @(negedge clk);
    checks++;
    if (done_cnt0 - d0 != 2 || tx0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_dones: %0d line=%b, required 2 and line 1", done_cnt0 - d0, tx0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int ts, td, d0;
    bit ok;
    sel = 0;
    d0  = done_cnt0;
    send(8'hC7, 1'b1, 1'b0, 1'b0);
    repeat (4 * CPB + 200) @(negedge clk);
    checks++;
    if (tx0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_bit3: line=%b, required 0", tx0);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx0 !== 1'b1 || if0.tx_ready !== 1'b1 || if0.tx_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_reset: tx=%b ready=%b done=%b, required 1 1 0",
               tx0, if0.tx_ready, if0.tx_done);
    end
    exp_q.delete();
    ok = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (tx0 !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok || done_cnt0 != d0) begin
      errors++;
      $display("FAIL abandoned_frame: dones=%0d idle_ok=%0d, required 0 dones and idle line",
               done_cnt0 - d0, ok);
    end
    send(8'h81, 1'b1, 1'b0, 1'b0);
    watch_frame("after_rst_0x81", 11, ts, td);
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt0 - d0 != 1) begin
      errors++;
      $display("FAIL after_rst done_count: %0d, required 1", done_cnt0 - d0);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    done_cnt0 = 0;
    done_cnt1 = 0;
    done_cnt2 = 0;
    sel       = 0;
    rst       = 1'b1;
    drv_data  = 8'h00;
    drv_start = 1'b0;
    test_reset();
    test_single_frame();
    test_parity_modes();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
